// File: rtl/ebu_ctrl_input.sv
// EBU per-controller request input stage.
// Captures an address-phase request that the arbiter defers, stalls the
// controller while it is held, and replays the captured request onto the
// shared AHB bus once the arbiter grants it. A hold counter raises a sticky
// timeout flag when a deferral lasts too long.
module ebu_ctrl_input #(
  parameter int PA_BITS  = 32,
  parameter int MAX_HOLD = 64,
  parameter int CNT_BITS = 8
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [PA_BITS-1:0] HADDRIn,
  input  logic [2:0]         HSIZEIn,
  input  logic [2:0]         HBURSTIn,
  input  logic [1:0]         HTRANSIn,
  input  logic               HWRITEIn,
  input  logic               Save,
  input  logic               Restore,
  input  logic               Disable,
  input  logic               Select,
  input  logic               HREADY,
  output logic [PA_BITS-1:0] HADDROut,
  output logic [2:0]         HSIZEOut,
  output logic [2:0]         HBURSTOut,
  output logic [1:0]         HTRANSOut,
  output logic               HWRITEOut,
  output logic               HREADYOut,
  output logic               Pending,
  output logic               HoldTimeout
);

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    HOLD   = 2'd1,
    REPLAY = 2'd2
  } state_t;

  localparam logic [1:0]          HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]          HTRANS_NONSEQ = 2'b10;
  localparam logic [CNT_BITS-1:0] HOLD_LIMIT    = CNT_BITS'(MAX_HOLD);

  state_t              state_q, state_d;
  logic [PA_BITS-1:0]  addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [2:0]          burst_q, burst_d;
  logic [1:0]          trans_q, trans_d;
  logic                write_q, write_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  logic capture;
  logic accept;

  // A deferred request is only worth capturing if it is an actual transfer.
  assign capture = Save && (HTRANSIn != HTRANS_IDLE);
  // Address phase of the replayed request is taken by the bus this cycle.
  assign accept  = Select && HREADY && !Disable;

  // State, saved request, hold counter and sticky timeout registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= PASS;
      addr_q    <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      trans_q   <= '0;
      write_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      trans_q   <= trans_d;
      write_q   <= write_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic; Save has priority over Restore in PASS.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PASS:    if (capture) state_d = HOLD;
      HOLD:    if (!Restore && !Disable) state_d = REPLAY;
      REPLAY: begin
        if (accept)       state_d = PASS;
        else if (Disable) state_d = HOLD;
      end
      default: state_d = PASS;
    endcase
  end

  // Saved-request capture and hold-cycle accounting.
  always_comb begin
    addr_d    = addr_q;
    size_d    = size_q;
    burst_d   = burst_q;
    trans_d   = trans_q;
    write_d   = write_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (state_q == PASS && capture) begin
      addr_d  = HADDRIn;
      size_d  = HSIZEIn;
      burst_d = HBURSTIn;
      // A SEQ beat cannot be replayed on its own, so it restarts as NONSEQ.
      trans_d = HTRANS_NONSEQ;
      write_d = HWRITEIn;
    end
    if (state_q == HOLD) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_BITS'(1);
      if (cnt_d >= HOLD_LIMIT) timeout_d = 1'b1;
    end
    if (state_q == REPLAY && accept) cnt_d = '0;
  end

  // Output mux: live pass-through, held/restored, or replay of saved request.
  always_comb begin
    HADDROut    = HADDRIn;
    HSIZEOut    = HSIZEIn;
    HBURSTOut   = HBURSTIn;
    HTRANSOut   = Disable ? HTRANS_IDLE : HTRANSIn;
    HWRITEOut   = HWRITEIn;
    HREADYOut   = HREADY && !Disable;
    Pending     = 1'b0;
    HoldTimeout = timeout_q;
    unique case (state_q)
      PASS: ;
      HOLD: begin
        Pending   = 1'b1;
        HREADYOut = 1'b0;
        if (Restore) begin
          HADDROut  = addr_q;
          HSIZEOut  = size_q;
          HBURSTOut = burst_q;
          HTRANSOut = trans_q;
          HWRITEOut = write_q;
        end
        if (Disable) HTRANSOut = HTRANS_IDLE;
      end
      REPLAY: begin
        Pending   = 1'b1;
        HADDROut  = addr_q;
        HSIZEOut  = size_q;
        HBURSTOut = burst_q;
        HTRANSOut = (Disable || !Select) ? HTRANS_IDLE : trans_q;
        HWRITEOut = write_q;
        HREADYOut = accept;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ebu_ctrl_input.sv
// Bench for ebu_ctrl_input: directed scenarios followed by randomized
// stimulus, all checked against a request-level reference model.
module tb_ebu_ctrl_input;

  localparam int PA       = 32;
  localparam int MAXH     = 4;
  localparam int CNTB     = 3;
  localparam int CNT_SAT  = (1 << CNTB) - 1;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [PA-1:0] HADDRIn;
  logic [2:0]    HSIZEIn, HBURSTIn;
  logic [1:0]    HTRANSIn;
  logic          HWRITEIn, Save, Restore, Disable, Select, HREADY;
  logic [PA-1:0] HADDROut;
  logic [2:0]    HSIZEOut, HBURSTOut;
  logic [1:0]    HTRANSOut;
  logic          HWRITEOut, HREADYOut, Pending, HoldTimeout;

  ebu_ctrl_input #(.PA_BITS(PA), .MAX_HOLD(MAXH), .CNT_BITS(CNTB)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HADDRIn(HADDRIn), .HSIZEIn(HSIZEIn), .HBURSTIn(HBURSTIn),
    .HTRANSIn(HTRANSIn), .HWRITEIn(HWRITEIn),
    .Save(Save), .Restore(Restore), .Disable(Disable), .Select(Select),
    .HREADY(HREADY),
    .HADDROut(HADDROut), .HSIZEOut(HSIZEOut), .HBURSTOut(HBURSTOut),
    .HTRANSOut(HTRANSOut), .HWRITEOut(HWRITEOut), .HREADYOut(HREADYOut),
    .Pending(Pending), .HoldTimeout(HoldTimeout)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a request is either absent, held awaiting grant, or
  // released for replay once the arbiter drops Restore and Disable.
  bit            have_req, released, tmo;
  int            holds;
  logic [PA-1:0] s_addr;
  logic [2:0]    s_size, s_burst;
  logic          s_write;

  task automatic model_reset();
    have_req = 0; released = 0; tmo = 0; holds = 0;
  endtask

  task automatic model_check(input string tag);
    logic [PA-1:0] ea; logic [2:0] es, eb; logic [1:0] et; logic ew, er, ep;
    if (!have_req) begin
      ea = HADDRIn; es = HSIZEIn; eb = HBURSTIn; ew = HWRITEIn;
      et = Disable ? 2'b00 : HTRANSIn;
      er = HREADY & ~Disable; ep = 0;
    end else if (!released) begin
      if (Restore) begin
        ea = s_addr; es = s_size; eb = s_burst; ew = s_write; et = 2'b10;
      end else begin
        ea = HADDRIn; es = HSIZEIn; eb = HBURSTIn; ew = HWRITEIn; et = HTRANSIn;
      end
      if (Disable) et = 2'b00;
      er = 0; ep = 1;
    end else begin
      ea = s_addr; es = s_size; eb = s_burst; ew = s_write;
      et = (Disable || !Select) ? 2'b00 : 2'b10;
      er = Select & HREADY & ~Disable; ep = 1;
    end
    check({tag, ".addr"},  64'(HADDROut),   64'(ea));
    check({tag, ".size"},  64'(HSIZEOut),   64'(es));
    check({tag, ".burst"}, 64'(HBURSTOut),  64'(eb));
    check({tag, ".trans"}, 64'(HTRANSOut),  64'(et));
    check({tag, ".write"}, 64'(HWRITEOut),  64'(ew));
    check({tag, ".rdy"},   64'(HREADYOut),  64'(er));
    check({tag, ".pend"},  64'(Pending),    64'(ep));
    check({tag, ".tmo"},   64'(HoldTimeout), 64'(tmo));
  endtask

  task automatic model_clock();
    if (!have_req) begin
      if (Save && HTRANSIn != 2'b00) begin
        have_req = 1; released = 0;
        s_addr = HADDRIn; s_size = HSIZEIn; s_burst = HBURSTIn; s_write = HWRITEIn;
      end
    end else if (!released) begin
      holds = (holds < CNT_SAT) ? holds + 1 : CNT_SAT;
      if (holds >= MAXH) tmo = 1;
      if (!Restore && !Disable) released = 1;
    end else begin
      if (Select && HREADY && !Disable) begin
        have_req = 0; holds = 0;
      end else if (Disable) released = 0;
    end
  endtask

  // Called at a negedge with inputs already driven; returns at next negedge.
  task automatic cyc(input string tag);
    #1 model_check(tag);
    @(posedge HCLK);
    model_clock();
    @(negedge HCLK);
  endtask

  task automatic drive(input logic [PA-1:0] a, input logic [1:0] t, input logic sv,
                       input logic rs, input logic ds, input logic sl, input logic hr);
    HADDRIn = a; HTRANSIn = t; Save = sv; Restore = rs; Disable = ds;
    Select = sl; HREADY = hr;
  endtask

  task automatic sync_reset();
    HRESET = 1'b1;
    #1 model_reset();
    check("rst.pend", 64'(Pending), 64'd0);
    check("rst.tmo",  64'(HoldTimeout), 64'd0);
    @(posedge HCLK); @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1; model_reset();
    HSIZEIn = 3'd2; HBURSTIn = 3'b000; HWRITEIn = 1'b0;
    drive(32'h0, 2'b00, 0, 0, 0, 0, 1);
    @(negedge HCLK);
    model_check("reset");
    @(negedge HCLK);
    HRESET = 1'b0;

    // Pass-through
    drive(32'h8000_0040, 2'b10, 0, 0, 0, 0, 1);
    #1 check("pass.addr", 64'(HADDROut), 64'h8000_0040);
    check("pass.trans", 64'(HTRANSOut), 64'd2);
    check("pass.rdy", 64'(HREADYOut), 64'd1);
    check("pass.pend", 64'(Pending), 64'd0);
    @(negedge HCLK);

    // Capture and replay
    HBURSTIn = 3'b011; HWRITEIn = 1'b1;
    drive(32'h1000, 2'b10, 1, 0, 1, 0, 1);
    cyc("cap.save");
    HBURSTIn = 3'b000; HWRITEIn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(32'h2000, 2'b11, 0, 1, 1, 0, 1);
      #1 check("cap.hold.trans", 64'(HTRANSOut), 64'd0);
      check("cap.hold.addr", 64'(HADDROut), 64'h1000);
      check("cap.hold.rdy", 64'(HREADYOut), 64'd0);
      cyc("cap.hold");
    end
    drive(32'h2000, 2'b11, 0, 0, 0, 1, 1);
    cyc("cap.release");
    #1 check("cap.rep.addr", 64'(HADDROut), 64'h1000);
    check("cap.rep.trans", 64'(HTRANSOut), 64'd2);
    check("cap.rep.rdy", 64'(HREADYOut), 64'd1);
    check("cap.rep.burst", 64'(HBURSTOut), 64'd3);
    check("cap.rep.write", 64'(HWRITEOut), 64'd1);
    cyc("cap.rep");
    #1 check("cap.after.pend", 64'(Pending), 64'd0);
    check("cap.after.tmo", 64'(HoldTimeout), 64'd1);
    cyc("cap.after");

    // Idle Save
    sync_reset();
    drive(32'h3000, 2'b00, 1, 0, 0, 1, 1);
    cyc("idle.save");
    #1 check("idle.pend", 64'(Pending), 64'd0);
    cyc("idle.next");

    // Replay wait
    drive(32'h4000, 2'b10, 1, 0, 1, 0, 1);
    cyc("rw.save");
    drive(32'h5000, 2'b10, 0, 0, 0, 1, 0);
    cyc("rw.release");
    for (int i = 0; i < 3; i++) begin
      #1 check("rw.wait.rdy", 64'(HREADYOut), 64'd0);
      check("rw.wait.addr", 64'(HADDROut), 64'h4000);
      cyc("rw.wait");
    end
    HREADY = 1'b1;
    #1 check("rw.done.rdy", 64'(HREADYOut), 64'd1);
    cyc("rw.done");
    #1 check("rw.after.pend", 64'(Pending), 64'd0);
    cyc("rw.after");

    // Timeout
    sync_reset();
    drive(32'h6000, 2'b11, 1, 0, 1, 0, 1);
    cyc("to.save");
    for (int i = 1; i <= 6; i++) begin
      drive(32'h7000, 2'b10, 0, 1, 1, 0, 1);
      #1 check("to.hold.tmo", 64'(HoldTimeout), 64'(i > MAXH));
      cyc("to.hold");
    end
    drive(32'h7000, 2'b10, 0, 0, 0, 1, 1);
    cyc("to.release");
    cyc("to.rep");
    #1 check("to.pass.tmo", 64'(HoldTimeout), 64'd1);
    check("to.pass.pend", 64'(Pending), 64'd0);
    cyc("to.pass");

    // Async reset mid-HOLD
    drive(32'h9000, 2'b10, 1, 0, 1, 0, 1);
    cyc("ar.save");
    drive(32'h9000, 2'b10, 0, 1, 1, 0, 1);
    cyc("ar.hold");
    #2 HRESET = 1'b1;
    #1 check("ar.pend", 64'(Pending), 64'd0);
    check("ar.tmo", 64'(HoldTimeout), 64'd0);
    model_reset();
    @(negedge HCLK);
    HRESET = 1'b0;
    drive(32'hA000, 2'b00, 0, 0, 0, 1, 1);
    #1 check("ar.norep.addr", 64'(HADDROut), 64'hA000);
    check("ar.norep.trans", 64'(HTRANSOut), 64'd0);
    cyc("ar.norep");
    #1 check("ar.norep2.pend", 64'(Pending), 64'd0);
    cyc("ar.norep2");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) sync_reset();
      HADDRIn  = $urandom;
      HSIZEIn  = 3'($urandom_range(0, 7));
      HBURSTIn = 3'($urandom_range(0, 7));
      HTRANSIn = 2'($urandom_range(0, 3));
      HWRITEIn = 1'($urandom_range(0, 1));
      Save     = ($urandom_range(0, 4) == 0);
      Restore  = ($urandom_range(0, 9) < 6);
      Disable  = ($urandom_range(0, 9) < 4);
      Select   = ($urandom_range(0, 9) < 7);
      HREADY   = ($urandom_range(0, 9) < 7);
      cyc("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
